// File: rtl/pipe_reg_elastic.sv
// rtl/pipe_reg_elastic.sv - chain of elastic skid-buffer stages with register-only ready
// Optional downstream-stall counter enabled by defining PIPE_REG_STALL_CNT_EN.
module pipe_reg_elastic #(
  parameter int               WIDTH  = 32,
  parameter int               STAGES = 1,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [31:0]      stall_cnt
);
  logic [STAGES-1:0] main_v, skid_v, stage_rdy, up_v, dn_rdy, acc, drn;
  logic [WIDTH-1:0]  main_d [STAGES];
  logic [WIDTH-1:0]  skid_d [STAGES];
  logic [WIDTH-1:0]  up_d   [STAGES];
  logic [STAGES:0]   v_chain, r_chain;

  // Ready depends only on the skid valid bit, so out_ready never reaches in_ready.
  assign stage_rdy = ~skid_v;
  assign v_chain   = {main_v, in_valid & ~flush};
  assign r_chain   = {out_ready, stage_rdy};
  assign up_v      = v_chain[STAGES-1:0];
  assign dn_rdy    = r_chain[STAGES:1];
  assign acc       = up_v & stage_rdy;
  assign drn       = main_v & dn_rdy;

  always_comb begin
    up_d[0] = in_data;
    for (int k = 1; k < STAGES; k++) up_d[k] = main_d[k-1];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      main_v <= '0;
      skid_v <= '0;
      for (int k = 0; k < STAGES; k++) begin
        main_d[k] <= BUBBLE;
        skid_d[k] <= BUBBLE;
      end
    end else if (flush) begin
      main_v <= '0;
      skid_v <= '0;
      for (int k = 0; k < STAGES; k++) begin
        main_d[k] <= BUBBLE;
        skid_d[k] <= BUBBLE;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (!main_v[k]) begin
          if (acc[k]) begin
            main_v[k] <= 1'b1;
            main_d[k] <= up_d[k];
          end
        end else if (!skid_v[k]) begin
          if (acc[k] && drn[k]) begin
            main_d[k] <= up_d[k];
          end else if (acc[k]) begin
            skid_v[k] <= 1'b1;
            skid_d[k] <= up_d[k];
          end else if (drn[k]) begin
            main_v[k] <= 1'b0;
          end
        end else if (drn[k]) begin
          main_d[k] <= skid_d[k];
          skid_v[k] <= 1'b0;
        end
      end
    end
  end

  assign in_ready  = stage_rdy[0];
  assign out_valid = main_v[STAGES-1];
  assign out_data  = main_d[STAGES-1];

`ifdef PIPE_REG_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_q <= '0;
    end else if (flush) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && stall_q != 32'hFFFF_FFFF) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// tb/tb_pipe_reg_elastic.sv - scoreboard bench for pipe_reg_elastic at STAGES=1,2,3
module tb_pipe_reg_elastic;
  localparam int         W   = 8;
  localparam logic [7:0] BUB = 8'hEE;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [2:0]   flush, in_valid, out_ready;
  logic         in_ready  [3];
  logic         out_valid [3];
  logic [W-1:0] in_data   [3];
  logic [W-1:0] out_data  [3];
  logic [31:0]  stall_cnt [3];

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    pipe_reg_elastic #(.WIDTH(W), .STAGES(g + 1), .BUBBLE(BUB)) u_dut (
      .CLK      (CLK),
      .RST      (RST),
      .flush    (flush[g]),
      .in_valid (in_valid[g]),
      .in_data  (in_data[g]),
      .in_ready (in_ready[g]),
      .out_valid(out_valid[g]),
      .out_data (out_data[g]),
      .out_ready(out_ready[g]),
      .stall_cnt(stall_cnt[g])
    );
  end

  int           n_checks = 0;
  int           n_fail   = 0;
  int           sel      = 0;
  int           n_pop    = 0;
  logic         tog_en   = 1'b0;
  logic [W-1:0] sb_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected beats are pushed on accept and popped on drain of the selected instance.
  always @(negedge CLK) begin
    if (RST) begin
      sb_q.delete();
    end else begin
      if (out_valid[sel] && out_ready[sel]) begin
        chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          chk("sb_data", 32'(out_data[sel]), 32'(sb_q.pop_front()));
          n_pop++;
        end
      end
      if (flush[sel]) sb_q.delete();
      else if (in_valid[sel] && in_ready[sel]) sb_q.push_back(in_data[sel]);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
    if (tog_en) out_ready[sel] = ~out_ready[sel];
  endtask

  task automatic put(input int s, input logic [W-1:0] d);
    in_valid[s] = 1'b1;
    in_data[s]  = d;
    step();
    in_valid[s] = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int t = 0;
    while (sb_q.size() != 0 && t < 200) begin
      step();
      t++;
    end
    step();
    chk(tag, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    int k, b, t;
    logic acc_now;
    flush = '0; in_valid = '0; out_ready = '0;
    for (int i = 0; i < 3; i++) in_data[i] = '0;
    repeat (2) @(posedge CLK);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_out_valid", 32'(out_valid[i]), 32'd0);
      chk("rst_out_data", 32'(out_data[i]), 32'(BUB));
      chk("rst_in_ready", 32'(in_ready[i]), 32'd1);
      chk("rst_stall_cnt", stall_cnt[i], 32'd0);
    end
    RST = 1'b0;

    // Back-to-back beats through one stage, one cycle latency.
    sel = 0; n_pop = 0; out_ready[0] = 1'b1;
    in_valid[0] = 1'b1;
    in_data[0] = 8'h11; chk("s1_in_ready", 32'(in_ready[0]), 32'd1); step();
    chk("s1_out_11", 32'(out_data[0]), 32'h11);
    in_data[0] = 8'h22; chk("s1_in_ready", 32'(in_ready[0]), 32'd1); step();
    chk("s1_out_22", 32'(out_data[0]), 32'h22);
    in_data[0] = 8'h33; chk("s1_in_ready", 32'(in_ready[0]), 32'd1); step();
    chk("s1_out_33", 32'(out_data[0]), 32'h33);
    chk("s1_out_valid", 32'(out_valid[0]), 32'd1);
    in_valid[0] = 1'b0; step();
    chk("s1_idle", 32'(out_valid[0]), 32'd0);
    chk("s1_pops", 32'(n_pop), 32'd3);

    // Fill main and skid with the output stalled, then release.
    n_pop = 0; out_ready[0] = 1'b0;
    put(0, 8'h0A);
    put(0, 8'h0B);
    in_valid[0] = 1'b1; in_data[0] = 8'h0C;
    chk("s2_full_ready", 32'(in_ready[0]), 32'd0);
    step(); step();
    chk("s2_hold_ready", 32'(in_ready[0]), 32'd0);
    chk("s2_hold_valid", 32'(out_valid[0]), 32'd1);
    chk("s2_hold_data", 32'(out_data[0]), 32'h0A);
    out_ready[0] = 1'b1;
    t = 0;
    while (!in_ready[0] && t < 20) begin step(); t++; end
    chk("s2_ready_back", 32'(in_ready[0]), 32'd1);
    step();
    in_valid[0] = 1'b0;
    wait_drain("s2_drain");
    chk("s2_pops", 32'(n_pop), 32'd3);

    // Three stages, out_ready toggling every cycle.
    sel = 2; n_pop = 0; out_ready[2] = 1'b1; tog_en = 1'b1;
    k = 0; b = 1;
    in_valid[2] = 1'b1; in_data[2] = 8'd1;
    while (b <= 8 && k < 100) begin
      acc_now = in_ready[2];
      step();
      k++;
      if (k == 1 || k == 2) chk("s3_lat_early", 32'(out_valid[2]), 32'd0);
      if (k == 3) begin
        chk("s3_lat_valid", 32'(out_valid[2]), 32'd1);
        chk("s3_lat_data", 32'(out_data[2]), 32'd1);
      end
      if (acc_now) begin b++; in_data[2] = W'(b); end
    end
    in_valid[2] = 1'b0;
    chk("s3_all_sent", 32'(b), 32'd9);
    wait_drain("s3_drain");
    tog_en = 1'b0; out_ready[2] = 1'b1;
    chk("s3_pops", 32'(n_pop), 32'd8);

    // Flush beats the simultaneous input beat.
    sel = 1; n_pop = 0; out_ready[1] = 1'b0;
    put(1, 8'h05);
    put(1, 8'h06);
    chk("s4_pre_data", 32'(out_data[1]), 32'h05);
    flush[1] = 1'b1; in_valid[1] = 1'b1; in_data[1] = 8'h07;
    step();
    flush[1] = 1'b0; in_valid[1] = 1'b0;
    chk("s4_valid", 32'(out_valid[1]), 32'd0);
    chk("s4_bubble", 32'(out_data[1]), 32'(BUB));
    chk("s4_ready", 32'(in_ready[1]), 32'd1);
    out_ready[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("s4_no_output", 32'(out_valid[1]), 32'd0);
    end
    chk("s4_pops", 32'(n_pop), 32'd0);

    // Asynchronous reset while the single stage is full.
    sel = 0; n_pop = 0; out_ready[0] = 1'b0;
    put(0, 8'h31);
    put(0, 8'h32);
    chk("s5_two", 32'(in_ready[0]), 32'd0);
    #2 RST = 1'b1;
    #1;
    chk("s5_rst_valid", 32'(out_valid[0]), 32'd0);
    chk("s5_rst_data", 32'(out_data[0]), 32'(BUB));
    chk("s5_rst_ready", 32'(in_ready[0]), 32'd1);
    chk("s5_rst_stall", stall_cnt[0], 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    in_valid[0] = 1'b1; in_data[0] = 8'h09; out_ready[0] = 1'b1;
    step();
    in_valid[0] = 1'b0;
    chk("s5_first_valid", 32'(out_valid[0]), 32'd1);
    chk("s5_first_data", 32'(out_data[0]), 32'h09);
    step();
    chk("s5_idle", 32'(out_valid[0]), 32'd0);
    chk("s5_pops", 32'(n_pop), 32'd1);

    // Stall counting then clear on flush.
    out_ready[0] = 1'b0;
    put(0, 8'h44);
    repeat (5) step();
`ifdef PIPE_REG_STALL_CNT_EN
    chk("s6_stall_cnt", stall_cnt[0], 32'd5);
`else
    chk("s6_stall_cnt", stall_cnt[0], 32'd0);
`endif
    flush[0] = 1'b1;
    step();
    flush[0] = 1'b0;
    chk("s6_stall_flush", stall_cnt[0], 32'd0);
    chk("s6_flush_valid", 32'(out_valid[0]), 32'd0);
    chk("s6_flush_data", 32'(out_data[0]), 32'(BUB));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_reg_elastic.md
PIPE_REG_ELASTIC -- requirements
Module: pipe_reg_elastic

Interface
REQ-001 Parameter WIDTH, default 32, payload width in bits (legal range 1..256).
REQ-002 Parameter STAGES, default 1, number of chained elastic stages (legal range 1..4).
REQ-003 Parameter BUBBLE, WIDTH bits, default '0, value written into data registers on reset and flush.
REQ-004 The module SHALL have the following ports, one per line: name, direction, width, meaning.
REQ-005 CLK  input  1  single clock; every register samples on its rising edge.
REQ-006 RST  input  1  reset, asynchronous and active-high.
REQ-007 flush  input  1  synchronous clear of all stages.
REQ-008 in_valid  input  1  upstream holds valid payload.
REQ-009 in_data  input  WIDTH  upstream payload.
REQ-010 in_ready  output  1  stage 0 can accept this cycle.
REQ-011 out_valid  output  1  last stage holds valid payload.
REQ-012 out_data  output  WIDTH  last-stage payload.
REQ-013 out_ready  input  1  downstream accepts this cycle.
REQ-014 stall_cnt  output  32  count of downstream-stall cycles (see Configuration).

Function
REQ-015 Each stage SHALL hold a main register and a skid register, each with a valid bit, giving states EMPTY, ONE (main valid) and TWO (main and skid valid).
REQ-016 Stage 0 accept: in_valid & in_ready & !flush. Stage k>0 accepts from stage k-1 on that stage's valid & ready handshake. Last-stage drain: out_valid & out_ready.
REQ-017 EMPTY: accept -> ONE, main <= input.
REQ-018 ONE: accept & drain -> ONE, main <= input. Accept & !drain -> TWO, skid <= input. !accept & drain -> EMPTY. Neither -> ONE, hold.
REQ-019 TWO: drain -> ONE, main <= skid. No accept is possible in TWO.
REQ-020 A stage's ready SHALL equal (state != TWO) and SHALL be a register-only function, with no combinational path from out_ready to in_ready.
REQ-021 out_valid and out_data SHALL be driven directly by the last stage's main valid bit and main register.
REQ-022 Latency: an accepted beat SHALL appear on out_data exactly STAGES cycles after acceptance when no stage is stalled.
REQ-023 Throughput: the block SHALL sustain one beat per cycle with in_valid and out_ready continuously high.
REQ-024 Ordering: beats SHALL exit in acceptance order, with no loss or duplication under any out_ready pattern.
REQ-025 Flush: on the next edge, all stages SHALL go to EMPTY and all data registers SHALL load BUBBLE.
REQ-026 Flush with in_valid in the same cycle: flush wins and the input beat SHALL NOT be accepted.
REQ-027 While the last stage is valid, out_data SHALL stay stable until drain, even while out_ready is low.

Reset
REQ-028 While RST is high, regardless of CLK, all stages SHALL be EMPTY and data registers SHALL hold BUBBLE.
REQ-029 While RST is high, out_valid=0, out_data=BUBBLE, in_ready=1 and stall_cnt=0.
REQ-030 Reset asserted mid-transfer SHALL discard all held beats.
REQ-031 The first accept SHALL be possible on the first rising edge after RST deasserts.

Configuration
REQ-032 Macro PIPE_REG_STALL_CNT_EN, when defined, SHALL make stall_cnt increment by 1 each cycle with out_valid & !out_ready.
REQ-033 With the macro defined, stall_cnt SHALL saturate at 32'hFFFF_FFFF and SHALL clear on flush.
REQ-034 With the macro undefined, the port SHALL remain present, tied to 32'h0, with no counter flops inferred.

Verification
REQ-035 Scenario 1: STAGES=1, out_ready=1, beats 0x11, 0x22, 0x33 on consecutive cycles -> out_data 0x11, 0x22, 0x33 on cycles 1, 2, 3; in_ready stays 1.
REQ-036 Scenario 2: STAGES=1, out_ready=0, beats 0xA, 0xB, 0xC -> 0xA in main, 0xB in skid, in_ready=0 and 0xC held upstream. Raise out_ready -> output order 0xA, 0xB, 0xC with no loss.
REQ-037 Scenario 3: STAGES=3, back-to-back beats 1..8 with out_ready toggling 1,0,1,0 -> output sequence exactly 1..8; first beat visible 3 cycles after its accept.
REQ-038 Scenario 4: STAGES=2, stages holding 0x5 and 0x6, flush=1 with in_valid=1 and in_data=0x7 -> next cycle out_valid=0, out_data=BUBBLE; 0x7 is never output.
REQ-039 Scenario 5: RST pulsed high between clock edges while state is TWO -> outputs immediately show the reset values of REQ-029; after release, beat 0x9 passes normally.
REQ-040 Scenario 6: with PIPE_REG_STALL_CNT_EN, out_valid=1 and out_ready=0 for 5 cycles -> stall_cnt=5, and 0 after flush. Without the macro -> stall_cnt=0 throughout.
